// File: rtl/rpi_accel_pkg.sv
// Shared definitions for the RPi instruction path (receiver and task_manager).
// Instruction layout, status codes and the receiver FSM state encoding.
package rpi_accel_pkg;

    localparam int unsigned INST_W = 80;

    // Field offsets inside RPi_inst
    localparam int unsigned LS_MSB     = 79;
    localparam int unsigned LS_LSB     = 72;
    localparam int unsigned ADDR_A_MSB = 71;
    localparam int unsigned ADDR_A_LSB = 48;
    localparam int unsigned ADDR_B_MSB = 47;
    localparam int unsigned ADDR_B_LSB = 24;
    localparam int unsigned ADDR_C_MSB = 23;
    localparam int unsigned ADDR_C_LSB = 0;

    typedef enum logic [3:0] {
        CODE_NONE     = 4'd0,
        CODE_ACCEPTED = 4'd1,
        CODE_DONE     = 4'd2,
        CODE_INVALID  = 4'd3,
        CODE_SHORT    = 4'd4,
        CODE_LONG     = 4'd5,
        CODE_NOSTART  = 4'd6,
        CODE_BUSY     = 4'd7,
        CODE_CHECKSUM = 4'd8
    } status_code_e;

    typedef enum logic [2:0] {
        ST_COLLECT,
        ST_DISPATCH,
        ST_ISSUE,
        ST_WAIT_START,
        ST_WAIT_DONE
    } rx_state_e;

    // Extract the logic_states byte of an instruction word
    function automatic logic [7:0] logic_states_of(input logic [INST_W-1:0] inst);
        return inst[LS_MSB:LS_LSB];
    endfunction

endpackage

// File: rtl/inst_frame_shifter.sv
// Byte-serial frame assembler: shadow shift register, saturating byte counter
// and (with INST_CHECKSUM_EN defined) a running XOR over all received bytes.
// Count and XOR clear at every frame end.
module inst_frame_shifter #(
    parameter int unsigned INST_BYTES  = 10,
    parameter int unsigned FRAME_BYTES = 10,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      shift_en,
    input  logic                      frame_end,
    input  logic [7:0]                rx_byte,
    output logic [INST_BYTES*8-1:0]   inst_bits,
    output logic [CNT_W-1:0]          byte_count,
    output logic                      checksum_ok
);

    logic [FRAME_BYTES*8-1:0] shadow_q, shadow_d;
    logic [CNT_W-1:0]         count_q, count_d;

    // Shift/count next-state; frame end clears the count
    always_comb begin
        shadow_d = shadow_q;
        count_d  = count_q;
        if (shift_en) begin
            shadow_d = {shadow_q[FRAME_BYTES*8-9:0], rx_byte};
            if (count_q != CNT_W'(FRAME_BYTES + 1)) begin
                count_d = count_q + CNT_W'(1);
            end
        end
        if (frame_end) begin
            count_d = '0;
        end
    end

    // Shadow and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q <= '0;
            count_q  <= '0;
        end else begin
            shadow_q <= shadow_d;
            count_q  <= count_d;
        end
    end

`ifdef INST_CHECKSUM_EN
    logic [7:0] xor_q, xor_d;

    // Running XOR; including the checksum byte, a good frame folds to zero
    always_comb begin
        xor_d = xor_q;
        if (shift_en) begin
            xor_d = xor_q ^ rx_byte;
        end
        if (frame_end) begin
            xor_d = '0;
        end
    end

    // XOR accumulator register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_q <= '0;
        end else begin
            xor_q <= xor_d;
        end
    end

    assign checksum_ok = (xor_q == 8'h00);
`else
    assign checksum_ok = 1'b1;
`endif

    assign inst_bits  = shadow_q[FRAME_BYTES*8-1 -: INST_BYTES*8];
    assign byte_count = count_q;

endmodule

// File: rtl/rpi_inst_receiver.sv
// Upstream stage of task_manager: commits byte-serial RPi frames into RPi_inst,
// issues a one-cycle execute_task, tracks task start/completion and exposes a
// status byte for SPI readback. Optional macro INST_CHECKSUM_EN appends an XOR
// checksum byte to each frame.
module rpi_inst_receiver
    import rpi_accel_pkg::*;
#(
    parameter int unsigned INST_BYTES    = 10,
    parameter int unsigned START_TIMEOUT = 16,
    parameter int unsigned DISPATCH_WAIT = 1024
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_active,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_byte,
    input  logic                    inst_valid,
    input  logic                    idle,
    output logic [INST_BYTES*8-1:0] RPi_inst,
    output logic                    execute_task,
    output logic                    busy,
    output logic [7:0]              tx_status
);

`ifdef INST_CHECKSUM_EN
    localparam int unsigned FRAME_BYTES = INST_BYTES + 1;
`else
    localparam int unsigned FRAME_BYTES = INST_BYTES;
`endif
    localparam int unsigned CNT_W = $clog2(FRAME_BYTES + 2);
    localparam int unsigned TMR_W =
        $clog2(DISPATCH_WAIT > START_TIMEOUT ? DISPATCH_WAIT : START_TIMEOUT) + 1;

    rx_state_e               state_q, state_d;
    status_code_e            code_q, code_d;
    logic [INST_BYTES*8-1:0] rpi_inst_q, rpi_inst_d;
    logic                    busy_q, busy_d;
    logic                    overrun_q, overrun_d;
    logic                    exec_q, exec_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic                    frame_active_q, frame_active_d;

    logic                    frame_end;
    logic                    shift_en;
    logic [INST_BYTES*8-1:0] inst_bits;
    logic [CNT_W-1:0]        byte_count;
    logic                    checksum_ok;

    assign frame_end = frame_active_q & ~frame_active;
    assign shift_en  = rx_valid & frame_active & (state_q == ST_COLLECT);

    inst_frame_shifter #(
        .INST_BYTES (INST_BYTES),
        .FRAME_BYTES(FRAME_BYTES),
        .CNT_W      (CNT_W)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_en   (shift_en),
        .frame_end  (frame_end),
        .rx_byte    (rx_byte),
        .inst_bits  (inst_bits),
        .byte_count (byte_count),
        .checksum_ok(checksum_ok)
    );

    // FSM next-state, status code, commit and overrun tracking
    always_comb begin
        state_d        = state_q;
        code_d         = code_q;
        rpi_inst_d     = rpi_inst_q;
        busy_d         = busy_q;
        overrun_d      = overrun_q;
        exec_d         = 1'b0;
        timer_d        = timer_q;
        frame_active_d = frame_active;

        case (state_q)
            ST_COLLECT: begin
                if (frame_end) begin
                    if (byte_count < CNT_W'(FRAME_BYTES)) begin
                        code_d = CODE_SHORT;
                    end else if (byte_count > CNT_W'(FRAME_BYTES)) begin
                        code_d = CODE_LONG;
                    end else if (!checksum_ok) begin
                        code_d = CODE_CHECKSUM;
                    end else begin
                        rpi_inst_d = inst_bits;
                        busy_d     = 1'b1;
                        overrun_d  = 1'b0;
                        timer_d    = '0;
                        state_d    = ST_DISPATCH;
                    end
                end
            end
            ST_DISPATCH: begin
                if (!inst_valid) begin
                    code_d  = CODE_INVALID;
                    busy_d  = 1'b0;
                    state_d = ST_COLLECT;
                end else if (idle) begin
                    exec_d  = 1'b1;
                    code_d  = CODE_ACCEPTED;
                    state_d = ST_ISSUE;
                end else if (timer_q == TMR_W'(DISPATCH_WAIT - 1)) begin
                    code_d  = CODE_BUSY;
                    busy_d  = 1'b0;
                    state_d = ST_COLLECT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_ISSUE: begin
                timer_d = '0;
                state_d = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (!idle) begin
                    state_d = ST_WAIT_DONE;
                end else if (timer_q == TMR_W'(START_TIMEOUT - 1)) begin
                    code_d  = CODE_NOSTART;
                    busy_d  = 1'b0;
                    state_d = ST_COLLECT;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (idle) begin
                    code_d  = CODE_DONE;
                    busy_d  = 1'b0;
                    state_d = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_COLLECT;
            end
        endcase

        // A dropped byte marks overrun; set wins over the commit-time clear
        if (rx_valid && (!frame_active || state_q != ST_COLLECT)) begin
            overrun_d = 1'b1;
        end
    end

    // State and output registers; execute_task is a flop so reset cannot glitch it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_COLLECT;
            code_q         <= CODE_NONE;
            rpi_inst_q     <= '0;
            busy_q         <= 1'b0;
            overrun_q      <= 1'b0;
            exec_q         <= 1'b0;
            timer_q        <= '0;
            frame_active_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            code_q         <= code_d;
            rpi_inst_q     <= rpi_inst_d;
            busy_q         <= busy_d;
            overrun_q      <= overrun_d;
            exec_q         <= exec_d;
            timer_q        <= timer_d;
            frame_active_q <= frame_active_d;
        end
    end

    assign RPi_inst     = rpi_inst_q;
    assign execute_task = exec_q;
    assign busy         = busy_q;
    assign tx_status    = {busy_q, overrun_q, 2'b00, code_q};

endmodule

// File: tb/tb_rpi_inst_receiver.sv
// Directed self-checking bench for rpi_inst_receiver.
module tb_rpi_inst_receiver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        frame_active;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        inst_valid;
    logic        idle;
    logic [79:0] RPi_inst;
    logic        execute_task;
    logic        busy;
    logic [7:0]  tx_status;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    logic [7:0] fq[$];

    localparam logic [79:0] INST_A = 80'hFF00_0000_0000_1000_0020;
    localparam logic [79:0] INST_B = 80'h0100_0001_0000_0200_0003;

    rpi_inst_receiver dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_active(frame_active),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .inst_valid  (inst_valid),
        .idle        (idle),
        .RPi_inst    (RPi_inst),
        .execute_task(execute_task),
        .busy        (busy),
        .tx_status   (tx_status)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (execute_task === 1'b1) pulses++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_inst(input logic [79:0] v);
        logic [7:0] b;
        logic [7:0] x;
        x = 8'h00;
        fq.delete();
        for (int i = 9; i >= 0; i--) begin
            b = v[i*8 +: 8];
            fq.push_back(b);
            x = x ^ b;
        end
`ifdef INST_CHECKSUM_EN
        fq.push_back(x);
`endif
    endtask

    task automatic load_fill(input int n, input logic [7:0] b);
        fq.delete();
        for (int i = 0; i < n; i++) fq.push_back(b);
    endtask

    // Returns one ns after the edge at which the frame end is seen
    task automatic send_frame;
        frame_active = 1'b1;
        tick();
        for (int i = 0; i < int'(fq.size()); i++) begin
            rx_valid = 1'b1;
            rx_byte  = fq[i];
            tick();
        end
        rx_valid     = 1'b0;
        frame_active = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of sequence");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b1; frame_active = 1'b0; rx_valid = 1'b0; rx_byte = 8'h00;
        inst_valid = 1'b1; idle = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_inst", RPi_inst, 80'h0);
        chk("reset_exec", execute_task, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_status", tx_status, 8'h00);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // Good frame, dispatch, start and completion
        load_inst(INST_A);
        send_frame();
        chk("t1_inst", RPi_inst, INST_A);
        chk("t1_busy_commit", busy, 1'b1);
        chk("t1_exec_commit", execute_task, 1'b0);
        tick();
        chk("t1_exec_pulse", execute_task, 1'b1);
        chk("t1_status_acc", tx_status, 8'h81);
        tick();
        chk("t1_exec_low", execute_task, 1'b0);
        chk("t1_pulses", pulses, 1);
        idle = 1'b0;
        repeat (3) tick();
        chk("t1_status_run", tx_status, 8'h81);
        idle = 1'b1;
        tick();
        chk("t1_status_done", tx_status, 8'h02);
        chk("t1_busy_done", busy, 1'b0);

        // Illegal instruction
        inst_valid = 1'b0;
        send_frame();
        tick();
        chk("t2_status", tx_status, 8'h03);
        chk("t2_busy", busy, 1'b0);
        tick();
        chk("t2_pulses", pulses, 1);
        inst_valid = 1'b1;

        // Short and long frames
        load_fill(9, 8'hAA);
        send_frame();
        chk("t3_short", tx_status, 8'h04);
        chk("t3_short_inst", RPi_inst, INST_A);
        load_fill(12, 8'h55);
        send_frame();
        chk("t3_long", tx_status, 8'h05);
        chk("t3_long_inst", RPi_inst, INST_A);

        // Dispatch wait expiry
        idle = 1'b0;
        load_inst(INST_B);
        send_frame();
        chk("t4_inst", RPi_inst, INST_B);
        chk("t4_wait", tx_status, 8'h85);
        repeat (1023) tick();
        chk("t4_wait_last", tx_status, 8'h85);
        tick();
        chk("t4_busy_code", tx_status, 8'h07);
        chk("t4_pulses", pulses, 1);

        // Start timeout
        idle = 1'b1;
        send_frame();
        tick();
        chk("t4_ns_pulse", execute_task, 1'b1);
        tick();
        repeat (15) tick();
        chk("t4_ns_before", tx_status, 8'h81);
        tick();
        chk("t4_nostart", tx_status, 8'h06);
        chk("t4_ns_pulses", pulses, 2);

        // Overrun while busy, then clear on next commit
        load_inst(INST_A);
        send_frame();
        tick(); tick();
        idle = 1'b0;
        tick();
        load_fill(3, 8'h11);
        send_frame();
        chk("t5_overrun", tx_status, 8'hC1);
        chk("t5_inst_kept", RPi_inst, INST_A);
        idle = 1'b1;
        tick();
        chk("t5_done_sticky", tx_status, 8'h42);
        load_inst(INST_B);
        send_frame();
        chk("t5_cleared", tx_status, 8'h82);
        tick();
        chk("t5_accept", tx_status, 8'h81);
        tick();
        idle = 1'b0; tick();
        idle = 1'b1; tick();
        chk("t5_done", tx_status, 8'h02);
        chk("t5_pulses", pulses, 4);
        rx_valid = 1'b1; rx_byte = 8'h33;
        tick();
        rx_valid = 1'b0;
        chk("t5_stray_byte", tx_status, 8'h42);

        // Asynchronous reset during WAIT_DONE
        load_inst(INST_A);
        send_frame();
        tick(); tick();
        idle = 1'b0;
        tick();
        chk("t6_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_inst", RPi_inst, 80'h0);
        chk("t6_status", tx_status, 8'h00);
        chk("t6_busy_rst", busy, 1'b0);
        chk("t6_exec", execute_task, 1'b0);
        idle = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();

`ifdef INST_CHECKSUM_EN
        load_inst(INST_A);
        fq[fq.size()-1] = fq[fq.size()-1] ^ 8'h01;
        send_frame();
        chk("t6_cks_bad", tx_status, 8'h08);
        chk("t6_cks_inst", RPi_inst, 80'h0);
        load_inst(INST_A);
        send_frame();
        chk("t6_cks_good", RPi_inst, INST_A);
        tick();
        chk("t6_cks_pulse", execute_task, 1'b1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
